// File: rtl/hc_pkg.sv
// Shared constants and FSM encoding for the timestamp producer and the
// hysteresis comparator that consumes its ts1/ts2 outputs.
package hc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      PUBLISH = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 8;
   // Hysteresis threshold of the comparator, kept beside the window settings.
   localparam int TH        = 5;

endpackage

// File: rtl/ts_capture_if.sv
// Bundle of the run control, event lines and published timestamps of ts_capture.
interface ts_capture_if
   import hc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   // valid is a one-cycle strobe with no ready: the consumer must take ts1/ts2
   // in the cycle valid is high; ts1/ts2 then hold until the next strobe.
   logic             en;
   logic             evt1;
   logic             evt2;
   logic [WIDTH-1:0] ts1;
   logic [WIDTH-1:0] ts2;
   logic             valid;
   logic             busy;
   state_t           state;

   modport master (output en, evt1, evt2,
                   input  ts1, ts2, valid, busy, state);
   modport slave  (input  en, evt1, evt2,
                   output ts1, ts2, valid, busy, state);

endinterface

// File: rtl/sync_edge.sv
// Synchronizes one asynchronous event line and emits a one-cycle pulse on its
// rising edge, SYNC_STAGES cycles after the first edge that samples it high.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge: SYNC_STAGES must be at least 2");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ts_capture.sv
// Repeating measurement window that records the first rising edge of two event
// lines as window-relative counts (0 = no event) and publishes them at window end.
module ts_capture
   import hc_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int WINDOW      = 200,
   parameter int SYNC_STAGES = 2
) (
   input logic         clk,
   input logic         rst,
   ts_capture_if.slave bus
);

   localparam logic [WIDTH-1:0] WIN_C = WIDTH'(WINDOW);

   if (WINDOW < 1 || WINDOW > (2**WIDTH) - 1) begin : g_bad_window
      $error("ts_capture: WINDOW must lie in 1 .. 2**WIDTH-1");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] cap1_q, cap1_d;
   logic [WIDTH-1:0] cap2_q, cap2_d;
   logic [WIDTH-1:0] ts1_q, ts1_d;
   logic [WIDTH-1:0] ts2_q, ts2_d;
   logic             rise1, rise2;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
      .clk (clk), .rst (rst), .d (bus.evt1), .rise (rise1)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
      .clk (clk), .rst (rst), .d (bus.evt2), .rise (rise2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap1_q  <= '0;
         cap2_q  <= '0;
         ts1_q   <= '0;
         ts2_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap1_q  <= cap1_d;
         cap2_q  <= cap2_d;
         ts1_q   <= ts1_d;
         ts2_q   <= ts2_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap1_d  = cap1_q;
      cap2_d  = cap2_q;
      ts1_d   = ts1_q;
      ts2_d   = ts2_q;
      case (state_q)
         IDLE: begin
            if (bus.en) state_d = ARM;
         end
         ARM: begin
            cap1_d  = '0;
            cap2_d  = '0;
            cnt_d   = WIDTH'(1);
            state_d = MEASURE;
         end
         MEASURE: begin
            if (rise1 && cap1_q == '0) cap1_d = cnt_q;
            if (rise2 && cap2_q == '0) cap2_d = cnt_q;
            if (cnt_q == WIN_C) begin
               // An edge on the last window cycle has not reached cap yet.
               ts1_d   = (cap1_q == '0 && rise1) ? WIN_C : cap1_q;
               ts2_d   = (cap2_q == '0 && rise2) ? WIN_C : cap2_q;
               cnt_d   = '0;
               state_d = PUBLISH;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         PUBLISH: begin
            state_d = bus.en ? ARM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ts1   = ts1_q;
   assign bus.ts2   = ts2_q;
   assign bus.valid = (state_q == PUBLISH);
   assign bus.busy  = (state_q != IDLE);
   assign bus.state = state_q;

endmodule

// File: tb/tb_ts_capture.sv
// Directed bench for ts_capture with WINDOW=20, SYNC_STAGES=2.
module tb_ts_capture;
   import hc_pkg::*;

   localparam int WIDTH  = 8;
   localparam int WINDOW = 20;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cur    = 0;

   ts_capture_if #(.WIDTH(WIDTH)) bus ();

   ts_capture #(.WIDTH(WIDTH), .WINDOW(WINDOW), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ARM and makes it window index 0.
   task automatic wait_arm(input string tag);
      int i;
      for (i = 0; i < 40; i++) begin
         tick();
         if (bus.state == ARM) break;
      end
      check({tag, "_arm_seen"}, 32'(i < 40), 32'd1);
      cur = 0;
   endtask

   // Index k in a window: 0 = ARM, 1..20 = MEASURE with cnt=k, 21 = PUBLISH.
   task automatic step_to(input int idx);
      while (cur < idx) begin
         tick();
         cur++;
      end
   endtask

   task automatic next_window(input string tag);
      step_to(WINDOW + 2);
      check({tag, "_next_arm"}, 32'(bus.state), 32'(ARM));
      cur = 0;
   endtask

   initial begin
      int vcount;
      rst      = 1'b1;
      bus.en   = 1'b0;
      bus.evt1 = 1'b0;
      bus.evt2 = 1'b0;
      #1;
      check("rst0_ts1", 32'(bus.ts1), 32'd0);
      check("rst0_ts2", 32'(bus.ts2), 32'd0);
      check("rst0_valid", 32'(bus.valid), 32'd0);
      check("rst0_busy", 32'(bus.busy), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_state", 32'(bus.state), 32'(IDLE));

      // Single capture per line: rise1 at cnt=3, rise2 at cnt=9
      bus.en = 1'b1;
      wait_arm("t2");
      check("t2_busy_arm", 32'(bus.busy), 32'd1);
      step_to(1);  bus.evt1 = 1'b1;
      step_to(2);  bus.evt1 = 1'b0;
      step_to(7);  bus.evt2 = 1'b1;
      step_to(8);  bus.evt2 = 1'b0;
      step_to(20);
      check("t2_valid_early", 32'(bus.valid), 32'd0);
      step_to(21);
      check("t2_valid", 32'(bus.valid), 32'd1);
      check("t2_ts1", 32'(bus.ts1), 32'd3);
      check("t2_ts2", 32'(bus.ts2), 32'd9);
      next_window("t2");
      check("t2_valid_after", 32'(bus.valid), 32'd0);

      // Empty window
      step_to(21);
      check("t3a_valid", 32'(bus.valid), 32'd1);
      check("t3a_ts1", 32'(bus.ts1), 32'd0);
      check("t3a_ts2", 32'(bus.ts2), 32'd0);
      next_window("t3a");

      // Edge on the final window cycle
      step_to(18); bus.evt1 = 1'b1;
      step_to(19); bus.evt1 = 1'b0;
      step_to(21);
      check("t3b_valid", 32'(bus.valid), 32'd1);
      check("t3b_ts1", 32'(bus.ts1), 32'd20);
      check("t3b_ts2", 32'(bus.ts2), 32'd0);
      next_window("t3b");

      // Simultaneous rises at cnt=5, later rise1 at cnt=12 ignored
      step_to(3);  bus.evt1 = 1'b1; bus.evt2 = 1'b1;
      step_to(4);  bus.evt1 = 1'b0; bus.evt2 = 1'b0;
      step_to(10); bus.evt1 = 1'b1;
      step_to(11); bus.evt1 = 1'b0;
      step_to(21);
      check("t4_ts1", 32'(bus.ts1), 32'd5);
      check("t4_ts2", 32'(bus.ts2), 32'd5);
      next_window("t4");

      // en dropped at cnt=7, rise2 at cnt=4
      step_to(2);  bus.evt2 = 1'b1;
      step_to(3);  bus.evt2 = 1'b0;
      step_to(7);  bus.en = 1'b0;
      step_to(20);
      check("t6_busy_meas", 32'(bus.busy), 32'd1);
      step_to(21);
      check("t6_valid", 32'(bus.valid), 32'd1);
      check("t6_ts1", 32'(bus.ts1), 32'd0);
      check("t6_ts2", 32'(bus.ts2), 32'd4);
      step_to(22);
      check("t6_state_idle", 32'(bus.state), 32'(IDLE));
      check("t6_busy_low", 32'(bus.busy), 32'd0);
      check("t6_valid_low", 32'(bus.valid), 32'd0);
      step_to(30);
      check("t6_hold_ts2", 32'(bus.ts2), 32'd4);
      check("t6_still_idle", 32'(bus.state), 32'(IDLE));

      // Asynchronous reset mid-cycle at cnt=10 of an active window
      bus.en = 1'b1;
      wait_arm("t1");
      step_to(1);  bus.evt1 = 1'b1;
      step_to(2);  bus.evt1 = 1'b0;
      step_to(10);
      #2 rst = 1'b1;
      #1;
      check("t1_ts1", 32'(bus.ts1), 32'd0);
      check("t1_ts2", 32'(bus.ts2), 32'd0);
      check("t1_valid", 32'(bus.valid), 32'd0);
      check("t1_busy", 32'(bus.busy), 32'd0);
      check("t1_state", 32'(bus.state), 32'(IDLE));
      bus.en = 1'b0;
      tick();
      rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.valid) vcount++;
      end
      check("t1_no_valid", 32'(vcount), 32'd0);
      check("t1_ts1_after", 32'(bus.ts1), 32'd0);

      // Held level from IDLE, then edge landing in PUBLISH
      bus.evt1 = 1'b1;
      tick(); tick(); tick();
      bus.en = 1'b1;
      wait_arm("t5");
      step_to(19); bus.evt2 = 1'b1;
      step_to(20); bus.evt2 = 1'b0;
      step_to(21);
      check("t5a_valid", 32'(bus.valid), 32'd1);
      check("t5a_ts1", 32'(bus.ts1), 32'd0);
      check("t5a_ts2", 32'(bus.ts2), 32'd0);
      next_window("t5a");
      step_to(5);  bus.en = 1'b0;
      step_to(6);  bus.evt2 = 1'b1;
      step_to(7);  bus.evt2 = 1'b0;
      step_to(21);
      check("t5b_valid", 32'(bus.valid), 32'd1);
      check("t5b_ts1", 32'(bus.ts1), 32'd0);
      check("t5b_ts2", 32'(bus.ts2), 32'd8);
      step_to(22);
      check("t5b_idle", 32'(bus.state), 32'(IDLE));
      bus.evt1 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
